// File: rtl/rule_firing_strength.sv
`default_nettype none
// ============================================================================
//  Module      : rule_firing_strength
//  Description : Groups incoming membership degrees into rules of DIM
//                antecedents. It clamps each degree to [0, 1.0] and combines
//                the degrees of a rule with a T-norm to form its firing
//                strength. It also reports a rule index and a per-pass sum of
//                all NUM_RULES strengths.
//                The T-norm is min() by default. Define PRODUCT_TNORM_EN to
//                use the truncated fixed-point product instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module rule_firing_strength #(
    parameter int DIM       = 3,
    parameter int NUM_RULES = 27,
    parameter int FRAC_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] antecedent_degree,
    input  logic        antecedent_degree_valid,
    output logic [31:0] firing_strength,
    output logic        firing_strength_valid,
    output logic [7:0]  rule_index,
    output logic [39:0] strength_sum,
    output logic        sum_valid
);

    localparam int              CNT_W     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CNT_W-1:0] LAST_DEG = CNT_W'(DIM - 1);
    localparam logic [7:0]      LAST_RULE = 8'(NUM_RULES - 1);
    localparam logic [31:0]     ONE       = 32'd1 << FRAC_BITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_deg_cnt;
    logic [31:0]      r_acc;
    logic [7:0]       r_rule_cnt;

    logic [31:0]      w_clamped;
    logic [31:0]      w_tnorm;
    logic [31:0]      w_combined;
    logic             w_first;
    logic             w_emit;

    // Clamp the incoming signed degree into the legal range [0, 1.0]
    always_comb begin
        w_clamped = antecedent_degree;
        if (antecedent_degree[31]) begin
            w_clamped = 32'd0;
        end else if (antecedent_degree > ONE) begin
            w_clamped = ONE;
        end
    end

`ifdef PRODUCT_TNORM_EN
    logic [63:0] w_prod;

    // Both operands are non-negative, so a logical shift truncates toward zero
    always_comb begin
        w_prod  = {32'd0, r_acc} * {32'd0, w_clamped};
        w_tnorm = 32'(w_prod >> FRAC_BITS);
    end
`else
    // Min T-norm of the running value and the new degree
    always_comb begin
        w_tnorm = (w_clamped < r_acc) ? w_clamped : r_acc;
    end
`endif

    // The first degree of a group loads directly; later degrees fold in with the T-norm
    always_comb begin
        w_first    = (r_state == IDLE);
        w_combined = w_first ? w_clamped : w_tnorm;
        w_emit     = antecedent_degree_valid && (r_state == ACC) && (r_deg_cnt == LAST_DEG);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: leave IDLE on any degree, return when the group completes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (antecedent_degree_valid) w_next_state = ACC;
            ACC:     if (w_emit) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Degree counter and running T-norm accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deg_cnt <= '0;
            r_acc     <= 32'd0;
        end else if (antecedent_degree_valid) begin
            r_acc     <= w_combined;
            r_deg_cnt <= w_emit ? '0 : r_deg_cnt + CNT_W'(1);
        end
    end

    // Strength/index/sum outputs; the sum clears the cycle after a pass ends
    // unless a new rule emits in that same cycle, in which case it restarts with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firing_strength       <= 32'd0;
            firing_strength_valid <= 1'b0;
            rule_index            <= 8'd0;
            r_rule_cnt            <= 8'd0;
            strength_sum          <= 40'd0;
            sum_valid             <= 1'b0;
        end else begin
            firing_strength_valid <= w_emit;
            sum_valid             <= w_emit && (r_rule_cnt == LAST_RULE);
            if (w_emit) begin
                firing_strength <= w_combined;
                rule_index      <= r_rule_cnt;
                r_rule_cnt      <= (r_rule_cnt == LAST_RULE) ? 8'd0 : r_rule_cnt + 8'd1;
                strength_sum    <= (sum_valid ? 40'd0 : strength_sum) + {8'd0, w_combined};
            end else if (sum_valid) begin
                strength_sum    <= 40'd0;
            end
        end
    end

endmodule
`default_nettype wire
